// File: rtl/alu_issue_unit.sv
// Fetch/decode/issue stage feeding the 4-stage pipelined ALU.
// Inserts one NOP bubble on a back-to-back register dependency and stops on HALT.
module alu_issue_unit #(
  parameter int IMEM_DEPTH = 64,
  parameter int PC_W       = 6
) (
  input  logic            clk1,
  input  logic            rst_n,
  input  logic            load_en,
  input  logic [PC_W-1:0] load_addr,
  input  logic [23:0]     load_data,
  input  logic            start,
  output logic [3:0]      rs1,
  output logic [3:0]      rs2,
  output logic [3:0]      rd,
  output logic [3:0]      func,
  output logic [7:0]      addr,
  output logic            busy,
  output logic            halted,
  output logic [PC_W-1:0] pc,
  output logic [15:0]     issue_cnt,
  output logic [15:0]     bubble_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STALL  = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  localparam logic [3:0] FUNC_NOP  = 4'd3;
  localparam logic [3:0] FUNC_HALT = 4'hF;
  localparam logic [7:0] ADDR_NOP  = 8'hFF;

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : (v + 16'd1);
  endfunction

  logic [23:0]     imem_r [IMEM_DEPTH];
  state_t          state_r, state_s;
  logic [PC_W-1:0] pc_r, pc_s;
  logic [15:0]     issue_cnt_r, issue_cnt_s, bubble_cnt_r, bubble_cnt_s;
  logic            sb_valid_r, sb_valid_s;
  logic [3:0]      sb_rd_r, sb_rd_s;
  logic [3:0]      rs1_r, rs1_s, rs2_r, rs2_s, rd_r, rd_s, func_r, func_s;
  logic [7:0]      addr_r, addr_s;
  logic            busy_r, busy_s, halted_r, halted_s;
  logic [23:0]     instr_s;
  logic            hazard_s, issue_en_s, load_ok_s;

  assign instr_s   = imem_r[pc_r];
  assign hazard_s  = sb_valid_r & ((instr_s[15:12] == sb_rd_r) | (instr_s[11:8] == sb_rd_r));
  assign load_ok_s = load_en & ((state_r == ST_IDLE) | (state_r == ST_HALTED));

  // Program memory write port; contents survive reset.
  always_ff @(posedge clk1) begin
    if (load_ok_s) begin
      imem_r[load_addr] <= load_data;
    end
  end

  // Next-state, scoreboard and issued-field selection.
  always_comb begin
    state_s      = state_r;
    pc_s         = pc_r;
    issue_cnt_s  = issue_cnt_r;
    bubble_cnt_s = bubble_cnt_r;
    sb_valid_s   = 1'b0;
    sb_rd_s      = sb_rd_r;
    issue_en_s   = 1'b0;
    func_s       = FUNC_NOP;
    rd_s         = 4'd0;
    rs1_s        = 4'd0;
    rs2_s        = 4'd0;
    addr_s       = ADDR_NOP;
    case (state_r)
      ST_IDLE, ST_HALTED: begin
        if (start) begin
          state_s      = ST_RUN;
          pc_s         = {PC_W{1'b0}};
          issue_cnt_s  = 16'd0;
          bubble_cnt_s = 16'd0;
          sb_rd_s      = 4'd0;
        end else begin
          state_s = state_r;
        end
      end
      ST_RUN: begin
        if (hazard_s) begin
          state_s      = ST_STALL;
          bubble_cnt_s = sat_inc(bubble_cnt_r);
        end else if (instr_s[23:20] == FUNC_HALT) begin
          state_s = ST_HALTED;
        end else begin
          issue_en_s = 1'b1;
        end
      end
      ST_STALL: begin
        // The bubble just cleared the scoreboard, so the held word is safe now.
        if (instr_s[23:20] == FUNC_HALT) begin
          state_s = ST_HALTED;
        end else begin
          state_s    = ST_RUN;
          issue_en_s = 1'b1;
        end
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
    if (issue_en_s) begin
      func_s      = instr_s[23:20];
      rd_s        = instr_s[19:16];
      rs1_s       = instr_s[15:12];
      rs2_s       = instr_s[11:8];
      addr_s      = instr_s[7:0];
      pc_s        = pc_r + PC_W'(1);
      issue_cnt_s = sat_inc(issue_cnt_r);
      sb_valid_s  = 1'b1;
      sb_rd_s     = instr_s[19:16];
    end else begin
      sb_rd_s = sb_rd_s;
    end
    busy_s   = (state_s == ST_RUN) | (state_s == ST_STALL);
    halted_s = (state_s == ST_HALTED);
  end

  // State, counters, scoreboard and registered ALU-facing outputs.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= ST_IDLE;
      pc_r         <= {PC_W{1'b0}};
      issue_cnt_r  <= 16'd0;
      bubble_cnt_r <= 16'd0;
      sb_valid_r   <= 1'b0;
      sb_rd_r      <= 4'd0;
      func_r       <= FUNC_NOP;
      rd_r         <= 4'd0;
      rs1_r        <= 4'd0;
      rs2_r        <= 4'd0;
      addr_r       <= ADDR_NOP;
      busy_r       <= 1'b0;
      halted_r     <= 1'b0;
    end else begin
      state_r      <= state_s;
      pc_r         <= pc_s;
      issue_cnt_r  <= issue_cnt_s;
      bubble_cnt_r <= bubble_cnt_s;
      sb_valid_r   <= sb_valid_s;
      sb_rd_r      <= sb_rd_s;
      func_r       <= func_s;
      rd_r         <= rd_s;
      rs1_r        <= rs1_s;
      rs2_r        <= rs2_s;
      addr_r       <= addr_s;
      busy_r       <= busy_s;
      halted_r     <= halted_s;
    end
  end

  assign rs1        = rs1_r;
  assign rs2        = rs2_r;
  assign rd         = rd_r;
  assign func       = func_r;
  assign addr       = addr_r;
  assign busy       = busy_r;
  assign halted     = halted_r;
  assign pc         = pc_r;
  assign issue_cnt  = issue_cnt_r;
  assign bubble_cnt = bubble_cnt_r;

endmodule

// File: tb/tb_alu_issue_unit.sv
// Directed bench for alu_issue_unit with a small downstream ALU model
// (operand read one edge, writeback the next) so missing bubbles corrupt results.
module tb_alu_issue_unit;
  localparam int PC_W = 6;
  localparam logic [3:0] F_ADD = 4'h0, F_SUB = 4'h1, F_MUL = 4'h2, F_NOP = 4'h3;
  localparam logic [3:0] F_OR = 4'h5, F_SHL = 4'h8, F_HALT = 4'hF;

  logic            clk1, rst_n, load_en, start;
  logic [PC_W-1:0] load_addr;
  logic [23:0]     load_data;
  logic [3:0]      rs1, rs2, rd, func;
  logic [7:0]      addr;
  logic            busy, halted;
  logic [PC_W-1:0] pc;
  logic [15:0]     issue_cnt, bubble_cnt;

  int n_vec = 0;
  int n_err = 0;

  alu_issue_unit #(.IMEM_DEPTH(64), .PC_W(PC_W)) dut (
    .clk1(clk1), .rst_n(rst_n), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data), .start(start), .rs1(rs1), .rs2(rs2), .rd(rd),
    .func(func), .addr(addr), .busy(busy), .halted(halted), .pc(pc),
    .issue_cnt(issue_cnt), .bubble_cnt(bubble_cnt)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  // Downstream ALU model: regbank[k]=k after clear.
  logic [7:0] rb [16];
  logic [7:0] dmem [256];
  logic       alu_clr;
  logic [3:0] ex_func, ex_rd;
  logic [7:0] ex_a, ex_b, ex_addr, ex_res;

  always_comb begin
    case (ex_func)
      F_ADD:   ex_res = ex_a + ex_b;
      F_SUB:   ex_res = ex_a - ex_b;
      F_MUL:   ex_res = ex_a * ex_b;
      F_NOP:   ex_res = ex_a;
      F_OR:    ex_res = ex_a | ex_b;
      F_SHL:   ex_res = ex_a << 1;
      default: ex_res = 8'd0;
    endcase
  end

  always @(posedge clk1) begin
    if (alu_clr) begin
      for (int k = 0; k < 16; k++) rb[k] <= 8'(k);
      ex_func <= F_NOP; ex_rd <= 4'd0; ex_a <= 8'd0; ex_b <= 8'd0; ex_addr <= 8'hFF;
    end else begin
      ex_func <= func; ex_rd <= rd; ex_addr <= addr;
      ex_a <= rb[rs1]; ex_b <= rb[rs2];
      rb[ex_rd] <= ex_res;
      dmem[ex_addr] <= ex_res;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [23:0] enc(input logic [3:0] f, input logic [3:0] d,
                                      input logic [3:0] a, input logic [3:0] b,
                                      input logic [7:0] ad);
    return {f, d, a, b, ad};
  endfunction

  task automatic step();
    @(negedge clk1);
  endtask

  task automatic load(input logic [PC_W-1:0] a, input logic [23:0] d);
    load_en = 1'b1; load_addr = a; load_data = d;
    step();
    load_en = 1'b0;
  endtask

  task automatic go();
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic clr_alu();
    alu_clr = 1'b1;
    step();
    alu_clr = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; load_en = 1'b0; start = 1'b0; load_addr = '0; load_data = 24'd0; alu_clr = 1'b1;
    step();
    chk("rst_func", 32'(func), 32'(F_NOP));
    chk("rst_addr", 32'(addr), 32'hFF);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_pc", 32'(pc), 32'd0);
    rst_n = 1'b1;
    step();
    alu_clr = 1'b0;

    // Independent stream
    load(6'd0, enc(F_ADD, 4'd10, 4'd3, 4'd5, 8'd125));
    load(6'd1, enc(F_MUL, 4'd12, 4'd3, 4'd8, 8'd126));
    load(6'd2, enc(F_HALT, 4'd0, 4'd0, 4'd0, 8'd0));
    step();
    chk("idle_busy", 32'(busy), 32'd0);
    clr_alu();
    go();
    chk("p1_busy", 32'(busy), 32'd1);
    chk("p1_s0_func", 32'(func), 32'(F_NOP));
    step();
    chk("p1_i0", {func, rd, rs1, rs2, addr}, 32'(enc(F_ADD, 4'd10, 4'd3, 4'd5, 8'd125)));
    step();
    chk("p1_i1", {func, rd, rs1, rs2, addr}, 32'(enc(F_MUL, 4'd12, 4'd3, 4'd8, 8'd126)));
    step();
    chk("p1_halt_nop", 32'(func), 32'(F_NOP));
    chk("p1_halted", 32'(halted), 32'd1);
    chk("p1_busy_end", 32'(busy), 32'd0);
    chk("p1_issue", 32'(issue_cnt), 32'd2);
    chk("p1_bubble", 32'(bubble_cnt), 32'd0);
    chk("p1_pc", 32'(pc), 32'd2);
    repeat (3) step();
    chk("p1_mem125", 32'(dmem[125]), 32'd8);
    chk("p1_mem126", 32'(dmem[126]), 32'd24);

    // RAW hazard
    load(6'd0, enc(F_ADD, 4'd10, 4'd3, 4'd5, 8'd120));
    load(6'd1, enc(F_SUB, 4'd14, 4'd10, 4'd5, 8'd121));
    load(6'd2, enc(F_HALT, 4'd0, 4'd0, 4'd0, 8'd0));
    clr_alu();
    go();
    chk("p2_cnt_clr", 32'(issue_cnt), 32'd0);
    step();
    chk("p2_i0_func", 32'(func), 32'(F_ADD));
    step();
    chk("p2_bubble_nop", 32'(func), 32'(F_NOP));
    chk("p2_bubble_cnt_mid", 32'(bubble_cnt), 32'd1);
    chk("p2_pc_held", 32'(pc), 32'd1);
    chk("p2_busy_stall", 32'(busy), 32'd1);
    step();
    chk("p2_i1", {func, rd, rs1, rs2, addr}, 32'(enc(F_SUB, 4'd14, 4'd10, 4'd5, 8'd121)));
    step();
    chk("p2_halted", 32'(halted), 32'd1);
    chk("p2_issue", 32'(issue_cnt), 32'd2);
    chk("p2_bubble", 32'(bubble_cnt), 32'd1);
    repeat (3) step();
    chk("p2_mem121", 32'(dmem[121]), 32'd3);

    // Distance-2 dependency
    load(6'd0, enc(F_ADD, 4'd10, 4'd3, 4'd5, 8'd100));
    load(6'd1, enc(F_OR, 4'd7, 4'd1, 4'd2, 8'd101));
    load(6'd2, enc(F_SUB, 4'd14, 4'd10, 4'd5, 8'd102));
    load(6'd3, enc(F_HALT, 4'd0, 4'd0, 4'd0, 8'd0));
    clr_alu();
    go();
    repeat (4) step();
    chk("p3_halted", 32'(halted), 32'd1);
    chk("p3_issue", 32'(issue_cnt), 32'd3);
    chk("p3_bubble", 32'(bubble_cnt), 32'd0);
    chk("p3_pc", 32'(pc), 32'd3);
    repeat (3) step();
    chk("p3_mem102", 32'(dmem[102]), 32'd3);
    chk("p3_mem101", 32'(dmem[101]), 32'd3);

    // Back-to-back chain
    load(6'd0, enc(F_SHL, 4'd13, 4'd7, 4'd0, 8'd90));
    load(6'd1, enc(F_SUB, 4'd11, 4'd13, 4'd3, 8'd91));
    load(6'd2, enc(F_ADD, 4'd9, 4'd11, 4'd11, 8'd92));
    load(6'd3, enc(F_HALT, 4'd0, 4'd0, 4'd0, 8'd0));
    clr_alu();
    go();
    step();
    chk("p4_i0_func", 32'(func), 32'(F_SHL));
    step();
    chk("p4_b0", 32'(func), 32'(F_NOP));
    step();
    chk("p4_i1_func", 32'(func), 32'(F_SUB));
    step();
    chk("p4_b1", 32'(func), 32'(F_NOP));
    step();
    chk("p4_i2_func", 32'(func), 32'(F_ADD));
    step();
    chk("p4_halted", 32'(halted), 32'd1);
    chk("p4_issue", 32'(issue_cnt), 32'd3);
    chk("p4_bubble", 32'(bubble_cnt), 32'd2);
    repeat (3) step();
    chk("p4_r9", 32'(rb[9]), 32'd22);
    chk("p4_mem92", 32'(dmem[92]), 32'd22);

    // Load/start gating during RUN
    clr_alu();
    go();
    load_en = 1'b1; load_addr = 6'd1; load_data = enc(F_MUL, 4'd1, 4'd2, 4'd2, 8'd50); start = 1'b1;
    step();
    load_en = 1'b0; start = 1'b0;
    chk("g_i0_func", 32'(func), 32'(F_SHL));
    step();
    chk("g_b0", 32'(func), 32'(F_NOP));
    load_en = 1'b1; load_addr = 6'd2; load_data = enc(F_MUL, 4'd1, 4'd2, 4'd2, 8'd51);
    step();
    load_en = 1'b0;
    chk("g_i1", {func, rd, rs1, rs2, addr}, 32'(enc(F_SUB, 4'd11, 4'd13, 4'd3, 8'd91)));
    repeat (3) step();
    chk("g_halted", 32'(halted), 32'd1);
    chk("g_issue", 32'(issue_cnt), 32'd3);
    chk("g_bubble", 32'(bubble_cnt), 32'd2);
    repeat (3) step();
    chk("g_r9", 32'(rb[9]), 32'd22);
    go();
    chk("g_rerun_issue", 32'(issue_cnt), 32'd0);
    chk("g_rerun_bubble", 32'(bubble_cnt), 32'd0);
    chk("g_rerun_busy", 32'(busy), 32'd1);
    chk("g_rerun_halted", 32'(halted), 32'd0);
    repeat (6) step();
    chk("g_rerun_done", 32'(issue_cnt), 32'd3);

    // Reset mid-run during STALL
    load(6'd0, enc(F_ADD, 4'd10, 4'd3, 4'd5, 8'd120));
    load(6'd1, enc(F_SUB, 4'd14, 4'd10, 4'd5, 8'd121));
    load(6'd2, enc(F_HALT, 4'd0, 4'd0, 4'd0, 8'd0));
    go();
    step();
    step();
    chk("r_in_stall", 32'(bubble_cnt), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("r_nop_func", 32'(func), 32'(F_NOP));
    chk("r_nop_addr", 32'(addr), 32'hFF);
    chk("r_busy", 32'(busy), 32'd0);
    chk("r_pc", 32'(pc), 32'd0);
    step();
    rst_n = 1'b1;
    repeat (3) step();
    chk("r_idle_busy", 32'(busy), 32'd0);
    chk("r_idle_func", 32'(func), 32'(F_NOP));
    chk("r_idle_pc", 32'(pc), 32'd0);
    chk("r_idle_issue", 32'(issue_cnt), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
